conv_mac_sched: RTL and testbench
=================================

// Module: conv_mac_sched
// PURPOSE
//   Sequencer for the P-lane convolution MAC array. Once the input buffer holds a full LENX-sample
//   vector, it walks the NOUT = LENX-LENF+1 outputs in groups of P and drives the shared addresses
//   and accumulator controls. It hands each finished group to the output buffer via valid/ready,
//   then frees the input buffer. Sits between the x buffer, the coefficient ROM, the MAC lanes and
//   the output buffer.
// PARAMETERS
//   LENX   64  input vector length
//   LENF   33  filter taps
//   P      8   parallel MAC lanes
//   ADDRX  6   x / output address width, >= clog2(LENX)
//   ADDRF  6   coefficient address width, >= clog2(LENF)
// PORTS
//   clk        in   1        clock
//   reset      in   1        synchronous, active-low reset (0 = reset)
//   x_full     in   1        x buffer holds LENX valid samples
//   x_release  out  1        1-cycle pulse; frees x buffer (x_full drops on the following edge)
//   addr_x     out  P*ADDRX  lane k read address at [k*ADDRX +: ADDRX]
//   addr_f     out  ADDRF    coefficient ROM address (shared by all lanes)
//   en_acc     out  1        MAC accumulate; aligned with ROM/x data (1-cycle read latency)
//   clr_acc    out  1        MAC accumulator clear
//   wr_valid   out  1        group result ready for the output buffer
//   wr_ready   in   1        output buffer accepts the group
//   wr_base    out  ADDRX    output index of lane 0 for this group
//   wr_mask    out  P        bit k = 1 if base+k < NOUT
//   busy       out  1        high in every state except IDLE
//   vec_done   out  1        1-cycle pulse when the last group is accepted
// BEHAVIOUR
//   - Reset (reset=0 at edge), including mid-operation: state IDLE, base=0, tap=0;
//     addr_x=0, addr_f=0, en_acc=0, clr_acc=1, wr_valid=0, wr_base=0, wr_mask=0, busy=0,
//     x_release=0, vec_done=0. Any partial group is abandoned.
//   - States: IDLE -> SETUP -> ISSUE -> DRAIN -> WRITE -> (SETUP | DONE) -> IDLE.
//   - IDLE: clr_acc=1. Move to SETUP when x_full=1 is sampled; otherwise stay, with no output activity.
//   - SETUP (1 cycle): clr_acc=1, tap=0, wr_mask computed for the current base.
//   - ISSUE (LENF cycles, tap 0..LENF-1): addr_f=tap.
//     addr_x[k] = min(base+k+tap, LENX-1), computed in ADDRX+1 bits before the clamp.
//     clr_acc=0. en_acc is addr-issue delayed by 1 cycle, so it is high for exactly LENF cycles,
//     starting in the 2nd ISSUE cycle.
//   - DRAIN (2 cycles): 1st cycle has en_acc=1 for the last tap; 2nd cycle lets the MAC register settle.
//     en_acc=0 in the 2nd DRAIN cycle and throughout WRITE.
//   - WRITE: wr_valid=1. wr_base and wr_mask are held stable, and addresses are frozen, until
//     wr_valid & wr_ready. clr_acc=0 (MAC holds its result).
//     On accept: base += P. Go to SETUP if the new base < NOUT, else to DONE.
//     wr_valid drops in the cycle after the accept.
//   - DONE (1 cycle): x_release=1 and vec_done=1, base=0, then IDLE.
//   - Groups per vector = ceil(NOUT/P). Lanes with base+k >= NOUT still receive clamped
//     addresses; their mask bit is 0 and they must not be written.
//   - Cycle count with wr_ready=1: a group takes 1+LENF+2+1 cycles (37 at defaults).
//   - The x_full check happens only in IDLE. x_full changes outside IDLE are ignored.
//   - wr_ready outside WRITE is ignored.
// TESTING
//   1. Defaults, x_full=1 sampled at cycle 0, wr_ready=1 -> SETUP c1, ISSUE c2-34, en_acc c3-35,
//      WRITE c37 (base 0, mask 0xFF), next WRITEs at c74/c111/c148 (base 8/16/24),
//      x_release+vec_done c149, busy=0 c150.
//   2. Address check -> group0 lane3 tap10: addr_x=13; group3 lane7 tap32: addr_x=63, addr_f=32.
//      P=5 build: 7 groups, last base 30, mask 5'b00011, lane4 tap32 addr clamped to 63.
//   3. wr_ready=0 for 5 WRITE cycles -> wr_valid=1 and base/mask/addresses constant, en_acc=0;
//      accept on 6th cycle, SETUP next cycle.
//   4. reset=0 in ISSUE tap 17 -> next cycle all outputs at reset values.
//      With reset=1 and x_full=1, restarts at SETUP with base 0.
//   5. x_full=0 held in IDLE for 100 cycles -> busy=0, en_acc=0, wr_valid=0, clr_acc=1 throughout.
//   6. Back-to-back: x_full reasserts 2 cycles after x_release -> new SETUP on the following cycle;
//      all 2 x 4 groups written with the correct bases.

Source files
------------

// File: rtl/conv_mac_sched.sv
// conv_mac_sched
//   Sequencer for a P-lane convolution MAC array. Once the x buffer holds a
//   full LENX-sample vector, the NOUT = LENX-LENF+1 outputs are processed in
//   groups of P. For each group the block:
//     - issues the shared coefficient addresses and the per-lane x addresses,
//     - drives the accumulator clear/enable,
//     - hands the finished group to the output buffer with a valid/ready handshake.
//   After the last group it releases the x buffer.
//
// Ports
//   clk        clock
//   reset      synchronous reset, active low (0 = reset)
//   x_full     x buffer holds LENX valid samples (looked at only while idle)
//   x_release  one-cycle pulse that frees the x buffer
//   addr_x     per-lane x read address, lane k at [k*ADDRX +: ADDRX]
//   addr_f     coefficient ROM address, shared by all lanes
//   en_acc     MAC accumulate, one cycle behind the address issue
//   clr_acc    MAC accumulator clear
//   wr_valid   group result ready for the output buffer
//   wr_ready   output buffer accepts the group
//   wr_base    output index of lane 0 for the current group
//   wr_mask    bit k set when wr_base+k is a real output (< NOUT)
//   busy       high whenever the sequencer is not idle
//   vec_done   one-cycle pulse after the last group is accepted
module conv_mac_sched #(
    parameter int LENX  = 64,
    parameter int LENF  = 33,
    parameter int P     = 8,
    parameter int ADDRX = 6,
    parameter int ADDRF = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x_full,
    output logic                 x_release,
    output logic [P*ADDRX-1:0]   addr_x,
    output logic [ADDRF-1:0]     addr_f,
    output logic                 en_acc,
    output logic                 clr_acc,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDRX-1:0]     wr_base,
    output logic [P-1:0]         wr_mask,
    output logic                 busy,
    output logic                 vec_done
);

    localparam int NOUT = LENX - LENF + 1;
    // One extra bit so base+k+tap can exceed LENX-1 before the clamp.
    localparam int BW   = ADDRX + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_DRAIN1,
        S_DRAIN2,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        base_q, base_d;
    logic [ADDRF-1:0]     tap_q, tap_d;

    logic [P*ADDRX-1:0]   addr_x_q, addr_x_d;
    logic [ADDRF-1:0]     addr_f_q, addr_f_d;
    logic                 en_acc_q, en_acc_d;
    logic                 clr_acc_q, clr_acc_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDRX-1:0]     wr_base_q, wr_base_d;
    logic [P-1:0]         wr_mask_q, wr_mask_d;
    logic                 busy_q, busy_d;
    logic                 x_release_q, x_release_d;
    logic                 vec_done_q, vec_done_d;

    // Lane k reads x[min(base+k+tap, LENX-1)]. Lanes past the end of the
    // vector still get a legal address; their results are masked off.
    function automatic logic [P*ADDRX-1:0] lane_addrs(input logic [BW-1:0]    base,
                                                      input logic [ADDRF-1:0] tap);
        logic [P*ADDRX-1:0] a;
        logic [BW-1:0]      s;
        a = '0;
        for (int k = 0; k < P; k++) begin
            s = base + BW'(k) + BW'(tap);
            if (s > BW'(LENX - 1)) begin
                s = BW'(LENX - 1);
            end
            a[k*ADDRX +: ADDRX] = s[ADDRX-1:0];
        end
        return a;
    endfunction

    function automatic logic [P-1:0] group_mask(input logic [BW-1:0] base);
        logic [P-1:0] m;
        m = '0;
        for (int k = 0; k < P; k++) begin
            m[k] = (int'(base) + k) < NOUT;
        end
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        tap_d   = tap_q;

        case (state_q)
            S_IDLE: begin
                if (x_full) begin
                    state_d = S_SETUP;
                    base_d  = '0;
                end
            end
            S_SETUP: begin
                state_d = S_ISSUE;
                tap_d   = '0;
            end
            S_ISSUE: begin
                if (tap_q == ADDRF'(LENF - 1)) begin
                    state_d = S_DRAIN1;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_WRITE;
            S_WRITE: begin
                if (wr_ready) begin
                    base_d  = base_q + BW'(P);
                    state_d = (base_d < BW'(NOUT)) ? S_SETUP : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                base_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered: they are derived here from the next state
        // so that each output lines up with the state it belongs to.
        x_release_d = 1'b0;
        vec_done_d  = 1'b0;
        clr_acc_d   = 1'b0;
        wr_valid_d  = 1'b0;
        // Read data for an address issued in ISSUE arrives one cycle later.
        en_acc_d    = (state_q == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        addr_x_d    = addr_x_q;
        addr_f_d    = addr_f_q;
        wr_base_d   = wr_base_q;
        wr_mask_d   = wr_mask_q;

        case (state_d)
            S_IDLE: begin
                clr_acc_d = 1'b1;
                addr_x_d  = '0;
                addr_f_d  = '0;
                wr_base_d = '0;
                wr_mask_d = '0;
            end
            S_SETUP: begin
                clr_acc_d = 1'b1;
                addr_x_d  = '0;
                addr_f_d  = '0;
                wr_base_d = base_d[ADDRX-1:0];
                wr_mask_d = group_mask(base_d);
            end
            S_ISSUE: begin
                addr_f_d = tap_d;
                addr_x_d = lane_addrs(base_d, tap_d);
            end
            S_WRITE: begin
                wr_valid_d = 1'b1;
            end
            S_DONE: begin
                x_release_d = 1'b1;
                vec_done_d  = 1'b1;
                clr_acc_d   = 1'b1;
                addr_x_d    = '0;
                addr_f_d    = '0;
                wr_base_d   = '0;
                wr_mask_d   = '0;
            end
            default: begin
                // DRAIN: addresses frozen, accumulator keeps running.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            tap_q       <= '0;
            addr_x_q    <= '0;
            addr_f_q    <= '0;
            en_acc_q    <= 1'b0;
            clr_acc_q   <= 1'b1;
            wr_valid_q  <= 1'b0;
            wr_base_q   <= '0;
            wr_mask_q   <= '0;
            busy_q      <= 1'b0;
            x_release_q <= 1'b0;
            vec_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            tap_q       <= tap_d;
            addr_x_q    <= addr_x_d;
            addr_f_q    <= addr_f_d;
            en_acc_q    <= en_acc_d;
            clr_acc_q   <= clr_acc_d;
            wr_valid_q  <= wr_valid_d;
            wr_base_q   <= wr_base_d;
            wr_mask_q   <= wr_mask_d;
            busy_q      <= busy_d;
            x_release_q <= x_release_d;
            vec_done_q  <= vec_done_d;
        end
    end

    assign addr_x    = addr_x_q;
    assign addr_f    = addr_f_q;
    assign en_acc    = en_acc_q;
    assign clr_acc   = clr_acc_q;
    assign wr_valid  = wr_valid_q;
    assign wr_base   = wr_base_q;
    assign wr_mask   = wr_mask_q;
    assign busy      = busy_q;
    assign x_release = x_release_q;
    assign vec_done  = vec_done_q;

endmodule

// File: tb/tb_conv_mac_sched.sv
// tb_conv_mac_sched
//   Bench for conv_mac_sched at default parameters, plus a second P=5
//   instance for the partial-last-group case. A per-group offset model
//   predicts every output each cycle; directed literal checks pin the model.
module tb_conv_mac_sched;

    localparam int LENX  = 64;
    localparam int LENF  = 33;
    localparam int P     = 8;
    localparam int ADDRX = 6;
    localparam int ADDRF = 6;
    localparam int NOUT  = LENX - LENF + 1;
    localparam int P2    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                x_full;
    logic                wr_ready;
    logic                x_release;
    logic [P*ADDRX-1:0]  addr_x;
    logic [ADDRF-1:0]    addr_f;
    logic                en_acc;
    logic                clr_acc;
    logic                wr_valid;
    logic [ADDRX-1:0]    wr_base;
    logic [P-1:0]        wr_mask;
    logic                busy;
    logic                vec_done;

    logic                x_full2;
    logic                x_release2;
    logic [P2*ADDRX-1:0] addr_x2;
    logic [ADDRF-1:0]    addr_f2;
    logic                en_acc2;
    logic                clr_acc2;
    logic                wr_valid2;
    logic [ADDRX-1:0]    wr_base2;
    logic [P2-1:0]       wr_mask2;
    logic                busy2;
    logic                vec_done2;

    always #5 clk = ~clk;

    conv_mac_sched #(.LENX(LENX), .LENF(LENF), .P(P), .ADDRX(ADDRX), .ADDRF(ADDRF)) dut (
        .clk(clk), .reset(reset), .x_full(x_full), .x_release(x_release),
        .addr_x(addr_x), .addr_f(addr_f), .en_acc(en_acc), .clr_acc(clr_acc),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_base(wr_base), .wr_mask(wr_mask),
        .busy(busy), .vec_done(vec_done)
    );

    conv_mac_sched #(.LENX(LENX), .LENF(LENF), .P(P2), .ADDRX(ADDRX), .ADDRF(ADDRF)) dut5 (
        .clk(clk), .reset(reset), .x_full(x_full2), .x_release(x_release2),
        .addr_x(addr_x2), .addr_f(addr_f2), .en_acc(en_acc2), .clr_acc(clr_acc2),
        .wr_valid(wr_valid2), .wr_ready(1'b1), .wr_base(wr_base2), .wr_mask(wr_mask2),
        .busy(busy2), .vec_done(vec_done2)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A vector is a sequence of groups; inside a group, offset 0 is the clear
    // cycle, offsets 1..LENF issue taps 0..LENF-1, two drain cycles follow and
    // from offset LENF+3 the group waits for the output buffer.
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    int m_off  = 0;
    int m_base = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_act = 1'b0; m_done = 1'b0; m_off = 0; m_base = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_act) begin
            if (x_full) begin
                m_act = 1'b1; m_off = 0; m_base = 0;
            end
        end else if (m_off >= LENF + 3) begin
            if (wr_ready) begin
                if (m_base + P < NOUT) begin
                    m_base = m_base + P;
                    m_off  = 0;
                end else begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                    m_base = 0;
                end
            end
        end else begin
            m_off++;
        end
    end

    logic [P*ADDRX-1:0] e_ax;
    logic [P-1:0]       e_mask;
    int                 e_af, e_tap, e_a;

    always @(negedge clk) begin
        if (chk_en) begin
            e_ax = '0; e_af = 0; e_mask = '0;
            if (m_act) begin
                for (int k = 0; k < P; k++) e_mask[k] = (m_base + k) < NOUT;
                if (m_off >= 1) begin
                    e_tap = (m_off <= LENF) ? m_off - 1 : LENF - 1;
                    e_af  = e_tap;
                    for (int k = 0; k < P; k++) begin
                        e_a = m_base + k + e_tap;
                        if (e_a > LENX - 1) e_a = LENX - 1;
                        e_ax[k*ADDRX +: ADDRX] = ADDRX'(e_a);
                    end
                end
            end
            check("m_busy",     busy,      64'(m_act | m_done));
            check("m_xrel",     x_release, 64'(m_done));
            check("m_vdone",    vec_done,  64'(m_done));
            check("m_clr",      clr_acc,   64'(!m_act || m_off == 0));
            check("m_en",       en_acc,    64'(m_act && m_off >= 2 && m_off <= LENF + 1));
            check("m_wvalid",   wr_valid,  64'(m_act && m_off >= LENF + 3));
            check("m_wbase",    wr_base,   64'(m_act ? m_base : 0));
            check("m_wmask",    wr_mask,   64'(e_mask));
            check("m_addr_f",   addr_f,    64'(e_af));
            check("m_addr_x",   addr_x,    64'(e_ax));
        end
    end

    // Accepted group bases, recorded at the handshake edge.
    int acc_q[$];
    always @(posedge clk) begin
        if (chk_en && reset && wr_valid && wr_ready) acc_q.push_back(int'(wr_base));
    end

    task automatic adv_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_vec_done(input int budget, input string name);
        int n;
        n = 0;
        while (vec_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tests++; fails++;
            $display("FAIL %s: no vec_done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    int exp_bases[8] = '{0, 8, 16, 24, 0, 8, 16, 24};
    int groups5, last_base5, last_mask5, last_lane4, last_af5, n5;

    initial begin
        reset = 1'b0; x_full = 1'b0; wr_ready = 1'b1; x_full2 = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_clr",   clr_acc, 1);
        check("rst_busy",  busy, 0);
        check("rst_en",    en_acc, 0);
        check("rst_wv",    wr_valid, 0);

        // Test 1: full vector, wr_ready=1, x_full sampled in cycle 0.
        reset = 1'b1; x_full = 1'b1; cyc = 0;
        adv_to(1);  check("t1_setup_busy", busy, 1); check("t1_setup_clr", clr_acc, 1);
        x_full = 1'b0;
        adv_to(2);  check("t1_c2_en", en_acc, 0); check("t1_c2_clr", clr_acc, 0);
        adv_to(3);  check("t1_c3_en", en_acc, 1);
        adv_to(12); check("t1_g0l3t10", addr_x[3*ADDRX +: ADDRX], 13); check("t1_af10", addr_f, 10);
        adv_to(35); check("t1_c35_en", en_acc, 1);
        adv_to(36); check("t1_c36_en", en_acc, 0); check("t1_c36_wv", wr_valid, 0);
        adv_to(37); check("t1_c37_wv", wr_valid, 1); check("t1_c37_base", wr_base, 0);
        check("t1_c37_mask", wr_mask, 8'hFF);
        adv_to(74);  check("t1_c74_wv", wr_valid, 1); check("t1_c74_base", wr_base, 8);
        adv_to(111); check("t1_c111_base", wr_base, 16);
        adv_to(145); check("t1_g3l7t32", addr_x[7*ADDRX +: ADDRX], 63); check("t1_af32", addr_f, 32);
        adv_to(148); check("t1_c148_base", wr_base, 24); check("t1_c148_wv", wr_valid, 1);
        adv_to(149); check("t1_xrel", x_release, 1); check("t1_vdone", vec_done, 1);
        adv_to(150); check("t1_idle_busy", busy, 0);

        // Test 3: output buffer stalls 5 WRITE cycles on group 0.
        x_full = 1'b1; wr_ready = 1'b0; cyc = 0;
        adv_to(1);  x_full = 1'b0;
        adv_to(41); check("t3_wv", wr_valid, 1); check("t3_base", wr_base, 0);
        check("t3_mask", wr_mask, 8'hFF); check("t3_en", en_acc, 0);
        check("t3_af", addr_f, 32); check("t3_l0", addr_x[0 +: ADDRX], 32);
        adv_to(42); check("t3_wv6", wr_valid, 1); wr_ready = 1'b1;
        adv_to(43); check("t3_setup_clr", clr_acc, 1); check("t3_setup_wv", wr_valid, 0);
        check("t3_setup_base", wr_base, 8);

        // Test 4: reset during ISSUE tap 17 of group 1 (group started at c43).
        adv_to(61); check("t4_tap17", addr_f, 17);
        reset = 1'b0;
        adv_to(62);
        check("t4_busy", busy, 0); check("t4_clr", clr_acc, 1); check("t4_en", en_acc, 0);
        check("t4_wv", wr_valid, 0); check("t4_ax", addr_x, 0); check("t4_af", addr_f, 0);
        check("t4_base", wr_base, 0); check("t4_mask", wr_mask, 0);
        check("t4_xrel", x_release, 0); check("t4_vdone", vec_done, 0);
        reset = 1'b1; x_full = 1'b1; cyc = 0;
        adv_to(1); check("t4_restart_busy", busy, 1); check("t4_restart_base", wr_base, 0);
        check("t4_restart_clr", clr_acc, 1);
        x_full = 1'b0;
        wait_vec_done(200, "t4_vec");

        // Test 5: idle with x_full low for 100 cycles.
        repeat (100) @(negedge clk);
        check("t5_busy", busy, 0); check("t5_clr", clr_acc, 1);

        // Test 6: two back-to-back vectors.
        acc_q.delete();
        x_full = 1'b1;
        @(negedge clk); x_full = 1'b0;
        begin
            int n;
            n = 0;
            while (x_release !== 1'b1 && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) begin
                tests++; fails++;
                $display("FAIL t6_xrel: no x_release within 200 cycles");
            end
        end
        @(negedge clk); check("t6_idle", busy, 0);
        @(negedge clk); x_full = 1'b1;
        @(negedge clk); check("t6_setup_busy", busy, 1); check("t6_setup_base", wr_base, 0);
        check("t6_setup_clr", clr_acc, 1);
        x_full = 1'b0;
        wait_vec_done(200, "t6_vec");
        @(negedge clk);
        check("t6_ngroups", acc_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_q.size()) check("t6_base", acc_q[i], exp_bases[i]);
        end

        // P=5 instance: 7 groups, last base 30, mask 00011, lane 4 clamped.
        groups5 = 0; last_base5 = -1; last_mask5 = -1; last_lane4 = -1; last_af5 = -1; n5 = 0;
        x_full2 = 1'b1;
        @(negedge clk); x_full2 = 1'b0;
        while (vec_done2 !== 1'b1 && n5 < 400) begin
            if (wr_valid2 === 1'b1) begin
                groups5++;
                last_base5 = int'(wr_base2);
                last_mask5 = int'(wr_mask2);
                last_lane4 = int'(addr_x2[4*ADDRX +: ADDRX]);
                last_af5   = int'(addr_f2);
            end
            @(negedge clk);
            n5++;
        end
        check("p5_done_seen", n5 < 400, 1);
        check("p5_groups", groups5, 7);
        check("p5_last_base", last_base5, 30);
        check("p5_last_mask", last_mask5, 5'b00011);
        check("p5_lane4", last_lane4, 63);
        check("p5_af", last_af5, 32);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
